pe_array_feeder: RTL and testbench



---
 rtl/pe_array_pkg.sv | 14 +
 rtl/pe_array_feeder_row_buffer.sv | 31 +++
 rtl/pe_array_feeder.sv | 150 +++++++++++++++
 tb/tb_pe_array_feeder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_array_pkg.sv
// Shared types and constants for the systolic PE array feeder.
package pe_array_pkg;
    localparam int MAX_PES      = 5;
    localparam int FLUSH_CYCLES = 5;
    localparam logic [15:0] FP16_ZERO = 16'h0000;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_W, S_LOAD_A, S_PRIME, S_STREAM, S_FLUSH, S_DONE
    } feeder_state_t;

    function automatic logic cfg_ok(input logic [2:0] v);
        return (v != 3'd0) && (v <= 3'd5);
    endfunction
endpackage

// File: rtl/pe_array_feeder_row_buffer.sv
// Row buffer: synchronous write, registered read. A cycle without a read
// enable loads zero, so the read register doubles as the Current_A output.
module row_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 32,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_q;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)      rd_q <= '0;
        else if (rd_en) rd_q <= mem[rd_addr];
        else            rd_q <= '0;
    end

    assign rd_data = rd_q;
endmodule

// File: rtl/pe_array_feeder.sv
// Feeder for the 1-D FP16 PE array: loads weights and one row, then primes,
// streams and flushes the array.
module pe_array_feeder
    import pe_array_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ROW_DEPTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [2:0]            cfg_filter_size,
    input  logic [2:0]            cfg_stride,
    output logic                  cfg_err,
    input  logic                  w_valid,
    output logic                  w_ready,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic                  a_last,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic                  array_rst_n,
    output logic [2:0]            filter_size,
    output logic [2:0]            stride,
    output logic [DATA_WIDTH-1:0] Current_A,
    output logic [DATA_WIDTH-1:0] Current_B1,
    output logic [DATA_WIDTH-1:0] Current_B2,
    output logic [DATA_WIDTH-1:0] Current_B3,
    output logic [DATA_WIDTH-1:0] Current_B4,
    output logic [DATA_WIDTH-1:0] Current_B5
);
    localparam int AW = $clog2(ROW_DEPTH);
    localparam logic [AW:0] ROW_LAST   = (AW+1)'(ROW_DEPTH - 1);
    localparam logic [AW:0] FLUSH_LAST = (AW+1)'(FLUSH_CYCLES - 1);

    feeder_state_t         state_q, state_d;
    logic [2:0]            fs_q, st_q, w_cnt_q;
    logic [DATA_WIDTH-1:0] b_q [MAX_PES];
    logic [AW-1:0]         wr_ptr_q, rd_addr;
    logic [AW:0]           row_len_q, cnt_q, cnt_nxt;
    logic                  cfg_err_q, done_q, ovf_q, arst_n_q;
    logic                  start_ok, w_fire, a_fire, a_full, rd_en;

    assign w_ready  = (state_q == S_LOAD_W);
    assign a_ready  = (state_q == S_LOAD_A);
    assign busy     = (state_q != S_IDLE);
    assign start_ok = start && cfg_ok(cfg_filter_size) && cfg_ok(cfg_stride);
    assign w_fire   = w_ready && w_valid;
    assign a_fire   = a_ready && a_valid;
    assign a_full   = (row_len_q == ROW_LAST);
    assign cnt_nxt  = cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        rd_en   = 1'b0;
        rd_addr = '0;
        case (state_q)
            S_IDLE:   if (start_ok) state_d = S_LOAD_W;
            S_LOAD_W: if (w_fire && (w_cnt_q == fs_q - 3'd1)) state_d = S_LOAD_A;
            S_LOAD_A: if (a_fire && (a_last || a_full)) state_d = S_PRIME;
            S_PRIME: begin
                // Fetch word 0 now so it appears on the first STREAM cycle.
                rd_en   = 1'b1;
                state_d = S_STREAM;
            end
            S_STREAM: begin
                if (cnt_nxt < row_len_q) begin
                    rd_en   = 1'b1;
                    rd_addr = cnt_nxt[AW-1:0];
                end
                if (cnt_q == row_len_q - 1'b1) state_d = S_FLUSH;
            end
            S_FLUSH:  if (cnt_q == FLUSH_LAST) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            fs_q      <= '0;
            st_q      <= '0;
            w_cnt_q   <= '0;
            wr_ptr_q  <= '0;
            row_len_q <= '0;
            cnt_q     <= '0;
            cfg_err_q <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            arst_n_q  <= 1'b0;
            for (int k = 0; k < MAX_PES; k++) b_q[k] <= '0;
        end else begin
            state_q   <= state_d;
            cfg_err_q <= (state_q == S_IDLE) && start && !start_ok;
            done_q    <= (state_d == S_DONE);
            arst_n_q  <= (state_d != S_PRIME);
            if (state_q == S_IDLE && start_ok) begin
                fs_q      <= cfg_filter_size;
                st_q      <= cfg_stride;
                ovf_q     <= 1'b0;
                w_cnt_q   <= '0;
                wr_ptr_q  <= '0;
                row_len_q <= '0;
                for (int k = 0; k < MAX_PES; k++)
                    if (k >= int'(cfg_filter_size)) b_q[k] <= '0;
            end
            if (w_fire) begin
                b_q[w_cnt_q] <= w_data;
                w_cnt_q      <= w_cnt_q + 3'd1;
            end
            if (a_fire) begin
                wr_ptr_q  <= wr_ptr_q + 1'b1;
                row_len_q <= row_len_q + 1'b1;
                if (a_full && !a_last) ovf_q <= 1'b1;
            end
            // cnt_q indexes the stream word, then the flush cycle.
            if (state_q == S_PRIME || (state_q == S_STREAM && state_d == S_FLUSH))
                cnt_q <= '0;
            else if (state_q == S_STREAM || state_q == S_FLUSH)
                cnt_q <= cnt_nxt;
        end
    end

    row_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(ROW_DEPTH), .AW(AW)) u_buf (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (a_fire),
        .wr_addr (wr_ptr_q),
        .wr_data (a_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (Current_A)
    );

    assign cfg_err     = cfg_err_q;
    assign done        = done_q;
    assign overflow    = ovf_q;
    assign array_rst_n = arst_n_q;
    assign filter_size = fs_q;
    assign stride      = st_q;
    assign Current_B1  = b_q[0];
    assign Current_B2  = b_q[1];
    assign Current_B3  = b_q[2];
    assign Current_B4  = b_q[3];
    assign Current_B5  = b_q[4];
endmodule

// File: tb/tb_pe_array_feeder.sv
// Scoreboard bench for pe_array_feeder: stimulus queues the expected stream,
// a negedge monitor pops and compares each streamed/flushed word.
module tb_pe_array_feeder;
    logic        clk = 1'b0;
    logic        reset, start, w_valid, a_valid, a_last;
    logic [2:0]  cfg_filter_size, cfg_stride;
    logic [15:0] w_data, a_data;
    logic        cfg_err, w_ready, a_ready, busy, done, overflow, array_rst_n;
    logic [2:0]  filter_size, stride;
    logic [15:0] Current_A, Current_B1, Current_B2, Current_B3, Current_B4, Current_B5;

    pe_array_feeder #(.DATA_WIDTH(16), .ROW_DEPTH(32)) dut (
        .clk(clk), .reset(reset), .start(start),
        .cfg_filter_size(cfg_filter_size), .cfg_stride(cfg_stride), .cfg_err(cfg_err),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_last(a_last),
        .busy(busy), .done(done), .overflow(overflow), .array_rst_n(array_rst_n),
        .filter_size(filter_size), .stride(stride), .Current_A(Current_A),
        .Current_B1(Current_B1), .Current_B2(Current_B2), .Current_B3(Current_B3),
        .Current_B4(Current_B4), .Current_B5(Current_B5)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    logic [15:0] exp_q [$];
    logic [15:0] wv [$];
    logic [15:0] row [$];
    logic [15:0] exp_b [5];
    logic [2:0]  exp_fs;
    bit          streaming = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: PRIME opens a window, each later cycle pops one expected word,
    // and done must coincide with an empty queue.
    initial forever begin
        @(negedge clk);
        if (reset) streaming = 0;
        else if (!streaming) begin
            if (!array_rst_n && busy) begin
                streaming = 1;
                chk("prime_a", Current_A, 0);
                chk("b1", Current_B1, exp_b[0]);
                chk("b2", Current_B2, exp_b[1]);
                chk("b3", Current_B3, exp_b[2]);
                chk("b4", Current_B4, exp_b[3]);
                chk("b5", Current_B5, exp_b[4]);
                chk("fs_out", filter_size, exp_fs);
            end
        end else if (done) begin
            chk("done_at_end", exp_q.size(), 0);
            exp_q.delete();
            streaming = 0;
        end else if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL stream_extra: got %0h with no expected word", Current_A);
            streaming = 0;
        end else begin
            chk("stream_a", Current_A, exp_q.pop_front());
        end
    end

    task automatic start_job(input logic [2:0] fs, input logic [2:0] st, input bit ok);
        start = 1'b1; cfg_filter_size = fs; cfg_stride = st;
        tick();
        start = 1'b0;
        if (ok) begin
            chk("start_busy", busy, 1);
            chk("start_cfg_err", cfg_err, 0);
            chk("start_ovf_clr", overflow, 0);
        end else begin
            chk("bad_cfg_err", cfg_err, 1);
            chk("bad_busy", busy, 0);
        end
    endtask

    task automatic send_w(input logic [15:0] d, input bit gaps);
        int n = 0;
        bit fired = 0;
        w_data = d;
        while (!fired && n < 200) begin
            w_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            fired = w_valid && w_ready;
            tick();
            n++;
        end
        w_valid = 1'b0;
        if (!fired) begin
            total++; bad++;
            $display("FAIL w_timeout: got no handshake want handshake");
        end
    endtask

    task automatic send_a(input logic [15:0] d, input bit last, input bit gaps);
        int n = 0;
        bit fired = 0;
        a_data = d; a_last = last;
        while (!fired && n < 200) begin
            a_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            fired = a_valid && a_ready;
            tick();
            n++;
        end
        a_valid = 1'b0; a_last = 1'b0;
        if (!fired) begin
            total++; bad++;
            $display("FAIL a_timeout: got no handshake want handshake");
        end
    endtask

    // Loads weights and row; leaves the bench in the PRIME cycle.
    task automatic load_job(input logic [2:0] fs, input logic [2:0] st,
                            input bit gaps, input bit last_end);
        int n = row.size();
        start_job(fs, st, 1);
        exp_fs = fs;
        for (int k = 0; k < int'(fs); k++) send_w(wv[k], gaps);
        for (int i = 0; i < n; i++) exp_q.push_back(row[i]);
        for (int i = 0; i < 5; i++) exp_q.push_back(16'h0000);
        for (int i = 0; i < n; i++) send_a(row[i], last_end && (i == n - 1), gaps);
        chk("prime_rst_n", array_rst_n, 0);
        chk("prime_a_ready", a_ready, 0);
        chk("ovf_after_load", overflow, last_end ? 0 : 1);
    endtask

    task automatic run_job(input logic [2:0] fs, input logic [2:0] st,
                           input bit gaps, input bit last_end, input bit poke);
        int cyc = 0;
        int n = row.size();
        load_job(fs, st, gaps, last_end);
        if (poke) begin
            start = 1'b1; cfg_filter_size = 3'd1; cfg_stride = 3'd1;
        end
        while (!done && cyc < 100) begin
            tick();
            start = 1'b0;
            cyc++;
        end
        chk("done_latency", cyc, n + 6);
        chk("done_fs_held", filter_size, fs);
        chk("done_st_held", stride, st);
        tick();
        chk("idle_after_done", busy, 0);
        chk("done_pulse", done, 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; w_valid = 1'b0; a_valid = 1'b0; a_last = 1'b0;
        cfg_filter_size = 3'd0; cfg_stride = 3'd0; w_data = 16'h0; a_data = 16'h0;
        tick(); tick();
        chk("rst_arst_n", array_rst_n, 0);
        chk("rst_busy", busy, 0);
        chk("rst_a", Current_A, 0);
        chk("rst_b1", Current_B1, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_fs", filter_size, 0);
        reset = 1'b0;
        tick();
        chk("post_rst_arst_n", array_rst_n, 1);

        // Basic job
        wv = '{16'h3C00, 16'h4000, 16'h4200};
        row = '{16'h3C00, 16'h3E00, 16'h4000, 16'h4100, 16'h4200, 16'h4400, 16'h4600, 16'h4800};
        exp_b = '{16'h3C00, 16'h4000, 16'h4200, 16'h0000, 16'h0000};
        run_job(3'd3, 3'd1, 0, 1, 0);

        // Rejected configs leave everything as it was
        start_job(3'd0, 3'd1, 0);
        start_job(3'd3, 3'd6, 0);
        tick();
        chk("bad_cfg_pulse", cfg_err, 0);
        chk("bad_b1_held", Current_B1, 16'h3C00);
        chk("bad_b3_held", Current_B3, 16'h4200);
        chk("bad_fs_held", filter_size, 3);
        chk("bad_st_held", stride, 1);

        // Backpressure
        wv = '{16'h4400, 16'h4500, 16'h4600, 16'h4700};
        row = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
        exp_b = '{16'h4400, 16'h4500, 16'h4600, 16'h4700, 16'h0000};
        run_job(3'd4, 3'd2, 1, 1, 0);

        // Overflow: 32 words without a_last
        wv = '{16'h3800, 16'h3900};
        row.delete();
        for (int i = 0; i < 32; i++) row.push_back(16'h5000 + 16'(i));
        exp_b = '{16'h3800, 16'h3900, 16'h0000, 16'h0000, 16'h0000};
        run_job(3'd2, 3'd1, 0, 0, 0);
        chk("ovf_sticky", overflow, 1);

        // Reset on the 4th streamed word
        wv = '{16'h3C00, 16'h4000, 16'h4200};
        row = '{16'hA000, 16'hA001, 16'hA002, 16'hA003, 16'hA004, 16'hA005};
        exp_b = '{16'h3C00, 16'h4000, 16'h4200, 16'h0000, 16'h0000};
        load_job(3'd3, 3'd3, 0, 1);
        tick(); tick(); tick(); tick();
        chk("pre_rst_word4", Current_A, 16'hA003);
        reset = 1'b1;
        #1;
        exp_q.delete();
        chk("mid_rst_arst_n", array_rst_n, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_a", Current_A, 0);
        chk("mid_rst_b2", Current_B2, 0);
        chk("mid_rst_fs", filter_size, 0);
        chk("mid_rst_st", stride, 0);
        tick();
        reset = 1'b0;
        tick();

        // Follow-up job after the abort
        row = '{16'h3C00, 16'h3E00, 16'h4000, 16'h4100, 16'h4200, 16'h4400, 16'h4600, 16'h4800};
        run_job(3'd3, 3'd1, 0, 1, 0);

        // Back-to-back: filter 5 (with an ignored start), then filter 2
        wv = '{16'h3C01, 16'h3C02, 16'h3C03, 16'h3C04, 16'h3C05};
        row = '{16'h0101, 16'h0202, 16'h0303, 16'h0404};
        exp_b = '{16'h3C01, 16'h3C02, 16'h3C03, 16'h3C04, 16'h3C05};
        run_job(3'd5, 3'd1, 0, 1, 1);
        wv = '{16'h4C00, 16'h4D00};
        row = '{16'h0A0A, 16'h0B0B, 16'h0C0C};
        exp_b = '{16'h4C00, 16'h4D00, 16'h0000, 16'h0000, 16'h0000};
        run_job(3'd2, 3'd2, 0, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
